// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic [3:0] be_mask(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m;
    case (f3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = 4'b0011 << off;
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    case (f3)
      F3_B, F3_BU: r = {4{wd[7:0]}};
      F3_H, F3_HU: r = {2{wd[15:0]}};
      default:     r = wd;
    endcase
    return r;
  endfunction

  // Unsigned sizes have no store form, so BU/HU stores are rejected here.
  function automatic logic access_legal(input logic [2:0] f3, input logic is_store,
                                        input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~is_store;
      F3_HU:   ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
// Purely combinational; words pass through untouched.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'(mem_rdata_i >> {off_i, 3'b000});
    half_lane = 16'(mem_rdata_i >> {off_i[1], 4'b0000});
    case (funct3_i)
      F3_B:    result_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   result_o = {24'h0, byte_lane};
      F3_H:    result_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   result_o = {16'h0, half_lane};
      default: result_o = mem_rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store stage, one access at a time over a req/gnt/rvalid bus.
// Zero-wait latency load 3 / store 2 / rejected 1; bus stalls bounded by TIMEOUT.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned width   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             is_store_i,
  input  logic [2:0]       funct3_i,
  input  logic [width-1:0] addr_i,
  input  logic [width-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [width-1:0] rdata_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [width-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [width-1:0] mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [width-1:0] mem_rdata_i
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  lsu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [width-1:0] addr_q, addr_d;
  logic [width-1:0] wdata_q, wdata_d;
  logic [width-1:0] rdata_q, rdata_d;
  logic [2:0]       f3_q, f3_d;
  logic             store_q, store_d;
  logic             err_q, err_d;
  logic [width-1:0] load_res;
  logic             expired;

  // Counter spans REQ and WAIT together, so TIMEOUT bounds the whole bus phase.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  load_align u_align (
    .mem_rdata_i (mem_rdata_i),
    .off_i       (addr_q[1:0]),
    .funct3_i    (f3_q),
    .result_o    (load_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    store_d = store_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (access_legal(funct3_i, is_store_i, addr_i[1:0])) begin
            addr_d  = addr_i;
            wdata_d = store_lanes(funct3_i, wdata_i);
            f3_d    = funct3_i;
            store_d = is_store_i;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt_i) begin
          state_d = store_q ? DONE : WAIT;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid_i) begin
          rdata_d = load_res;
          state_d = DONE;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= 3'b000;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      store_q <= store_d;
      err_q   <= err_d;
    end
  end

  assign busy_o      = (state_q == REQ) || (state_q == WAIT);
  assign done_o      = (state_q == DONE);
  assign err_o       = done_o & err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = mem_req_o & store_q;
  assign mem_be_o    = mem_req_o ? be_mask(f3_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr_o  = {addr_q[width-1:2], 2'b00};
  assign mem_wdata_o = wdata_q;

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i && !expired) |=>
      (mem_req_o && $stable(mem_addr_o) && $stable(mem_be_o) && $stable(mem_wdata_o)));

  a_done_pulse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |=> !done_o);

endmodule

// File: tb/tb_load_store_unit.sv
// Vector table plus random traffic against a byte-level reference model.
module tb_load_store_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.width(32), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_store_i(is_store),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy), .done_o(done), .err_o(err), .rdata_o(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  typedef struct {
    int          lat;
    logic        err;
    int          reqc;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } obs_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          gd;
    int          rd;
    logic [31:0] word;
    int          e_lat;
    logic        e_err;
    int          e_reqc;
    logic [3:0]  e_be;
    logic [31:0] e_maddr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'h0);
    chk({tag, ".done"},      32'(done),      32'h0);
    chk({tag, ".err"},       32'(err),       32'h0);
    chk({tag, ".rdata"},     rdata,          32'h0);
    chk({tag, ".mem_req"},   32'(mem_req),   32'h0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'h0);
    chk({tag, ".mem_be"},    32'(mem_be),    32'h0);
    chk({tag, ".mem_addr"},  mem_addr,       32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'h0);
  endtask

  // Reference: legality by size/alignment, timing by counting bus cycles against TO.
  function automatic obs_t model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int gd, input int rd,
                                 input logic [31:0] word, input logic [31:0] prev);
    obs_t   m;
    int     off, nbytes;
    bit     legal;
    longint v;
    off    = int'(a % 4);
    nbytes = 1 << f3[1:0];
    legal  = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && !(st && f3[2]) && (off % nbytes == 0);
    m = '{lat: 1, err: 1'b1, reqc: 0, be: 4'h0, maddr: 32'h0, we: 1'b0, wdata: 32'h0, rdata: prev};
    if (!legal) return m;
    m.err   = 1'b0;
    m.maddr = a & ~32'h3;
    m.we    = st;
    m.be    = 4'(((1 << nbytes) - 1) << off);
    if (nbytes == 1)      m.wdata = 32'(wd[7:0])  * 32'h0101_0101;
    else if (nbytes == 2) m.wdata = 32'(wd[15:0]) * 32'h0001_0001;
    else                  m.wdata = wd;
    if (gd + 1 > TO) begin
      m.reqc = TO; m.lat = 1 + TO; m.err = 1'b1;
    end else begin
      m.reqc = gd + 1;
      if (st) m.lat = gd + 2;
      else if (gd + rd + 2 > TO) begin
        m.lat = 1 + TO; m.err = 1'b1;
      end else begin
        m.lat = gd + rd + 3;
        v = (longint'(word) >> (8 * off)) & ((64'sd1 << (8 * nbytes)) - 1);
        if (!f3[2] && nbytes < 4 && v >= (64'sd1 << (8 * nbytes - 1)))
          v = v - (64'sd1 << (8 * nbytes));
        m.rdata = v[31:0];
      end
    end
    return m;
  endfunction

  // Drives one access; the bus grants after gd refused REQ cycles and returns data after rd idle WAIT cycles.
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int gd, input int rd,
                            input logic [31:0] word, input bit noise, output obs_t o);
    int cyc, req_c, wait_c;
    bit seen;
    o = '{lat: -1, err: 1'b0, reqc: 0, be: 4'h0, maddr: 32'h0, we: 1'b0, wdata: 32'h0, rdata: 32'h0};
    cyc = 0; req_c = 0; wait_c = 0; seen = 0;
    @(posedge clk); #1;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd; mem_rdata = word;
    while (!seen && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      start    = noise & (busy | done) & 1'($urandom_range(0, 1));
      addr     = $urandom;
      wdata    = $urandom;
      funct3   = 3'($urandom_range(0, 7));
      is_store = 1'($urandom_range(0, 1));
      if (mem_req) begin
        mem_gnt    = (req_c == gd);
        mem_rvalid = noise & 1'($urandom_range(0, 1));
      end else if (busy) begin
        mem_rvalid = (wait_c == rd);
        mem_gnt    = noise & 1'($urandom_range(0, 1));
      end else begin
        mem_gnt    = 1'b0;
        mem_rvalid = noise & 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (mem_req) begin
        if (req_c == 0) begin
          o.be = mem_be; o.maddr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else begin
          chk("req_be_stable",    32'(mem_be), 32'(o.be));
          chk("req_addr_stable",  mem_addr,    o.maddr);
          chk("req_wdata_stable", mem_wdata,   o.wdata);
        end
        req_c++;
      end else begin
        chk("be_without_req", 32'(mem_be), 32'h0);
        if (busy) wait_c++;
      end
      if (done) begin
        seen = 1; o.lat = cyc; o.err = err; o.rdata = rdata;
      end
    end
    o.reqc = req_c;
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL bound: no done pulse within 64 cycles (got none, required one)");
    end
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'h0);
  endtask

  task automatic cmp(input string tag, input obs_t g, input obs_t e);
    chk({tag, ".latency"},  32'(g.lat),  32'(e.lat));
    chk({tag, ".err"},      32'(g.err),  32'(e.err));
    chk({tag, ".req_cyc"},  32'(g.reqc), 32'(e.reqc));
    chk({tag, ".rdata"},    g.rdata,     e.rdata);
    if (e.reqc > 0) begin
      chk({tag, ".be"},    32'(g.be), 32'(e.be));
      chk({tag, ".maddr"}, g.maddr,   e.maddr);
      chk({tag, ".we"},    32'(g.we), 32'(e.we));
      if (e.we) chk({tag, ".wdata"}, g.wdata, e.wdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[15];
    obs_t        g, e;
    logic [31:0] exp_rdata;
    logic        r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, r_word;
    int          r_gd, r_rd;

    //            st    f3      addr          wdata         gd   rd  word          lat err   reqc be       maddr         wdata         rdata
    vt[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,         0,   0, 32'h80FF_1234, 3, 1'b0, 1, 4'b1000, 32'h0000_1000, 32'h0,         32'hFFFF_FF80};
    vt[1]  = '{1'b0, 3'b101, 32'h0000_2002, 32'h0,         0,   0, 32'hBEEF_0000, 3, 1'b0, 1, 4'b1100, 32'h0000_2000, 32'h0,         32'h0000_BEEF};
    vt[2]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,         0,   0, 32'hBEEF_0000, 3, 1'b0, 1, 4'b1100, 32'h0000_2000, 32'h0,         32'hFFFF_BEEF};
    vt[3]  = '{1'b1, 3'b001, 32'h0010_0002, 32'h1234_ABCD, 3,   0, 32'h0,         5, 1'b0, 4, 4'b1100, 32'h0010_0000, 32'hABCD_ABCD, 32'hFFFF_BEEF};
    vt[4]  = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,         0,   0, 32'h0,         1, 1'b1, 0, 4'b0000, 32'h0,         32'h0,         32'hFFFF_BEEF};
    vt[5]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         100, 0, 32'h1111_1111, 9, 1'b1, 8, 4'b1111, 32'h0000_0100, 32'h0,         32'hFFFF_BEEF};
    vt[6]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,         1,   2, 32'hCAFE_F00D, 6, 1'b0, 2, 4'b1111, 32'h0000_0104, 32'h0,         32'hCAFE_F00D};
    vt[7]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 0,   0, 32'h0,         2, 1'b0, 1, 4'b0010, 32'h0000_3000, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    vt[8]  = '{1'b1, 3'b100, 32'h0000_3000, 32'h0,         0,   0, 32'h0,         1, 1'b1, 0, 4'b0000, 32'h0,         32'h0,         32'hCAFE_F00D};
    vt[9]  = '{1'b0, 3'b011, 32'h0000_3000, 32'h0,         0,   0, 32'h0,         1, 1'b1, 0, 4'b0000, 32'h0,         32'h0,         32'hCAFE_F00D};
    vt[10] = '{1'b0, 3'b100, 32'h0000_4002, 32'h0,         0,   0, 32'h1280_3456, 3, 1'b0, 1, 4'b0100, 32'h0000_4000, 32'h0,         32'h0000_0080};
    vt[11] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         2, 100, 32'h0,         9, 1'b1, 3, 4'b1111, 32'h0000_0200, 32'h0,         32'h0000_0080};
    vt[12] = '{1'b1, 3'b010, 32'h0000_5000, 32'hDEAD_BEEF, 7,   0, 32'h0,         9, 1'b0, 8, 4'b1111, 32'h0000_5000, 32'hDEAD_BEEF, 32'h0000_0080};
    vt[13] = '{1'b0, 3'b010, 32'h0000_6000, 32'h0,         0,   6, 32'h0BAD_CAFE, 9, 1'b0, 1, 4'b1111, 32'h0000_6000, 32'h0,         32'h0BAD_CAFE};
    vt[14] = '{1'b0, 3'b001, 32'h0000_7001, 32'h0,         0,   0, 32'h0,         1, 1'b1, 0, 4'b0000, 32'h0,         32'h0,         32'h0BAD_CAFE};

    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #3;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      run_access(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].gd, vt[i].rd, vt[i].word, 1'b0, g);
      e = '{lat: vt[i].e_lat, err: vt[i].e_err, reqc: vt[i].e_reqc, be: vt[i].e_be,
            maddr: vt[i].e_maddr, we: vt[i].st, wdata: vt[i].e_wdata, rdata: vt[i].e_rdata};
      cmp($sformatf("vec%0d", i), g, e);
    end

    // Reset while a load waits for read data: everything clears at once, no done, late rvalid ignored.
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0044;
    wdata = 32'h5A5A_5A5A; mem_rdata = 32'h1122_3344;
    @(posedge clk); #1;
    start = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_reset_in_wait", 32'({busy, mem_req}), 32'h2);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      chk("late_rvalid.done",  32'(done), 32'h0);
      chk("late_rvalid.busy",  32'(busy), 32'h0);
      chk("late_rvalid.rdata", rdata,     32'h0);
    end
    mem_rvalid = 1'b0;
    exp_rdata = 32'h0;

    run_access(1'b0, 3'b100, 32'h0000_8001, 32'h0, 0, 0, 32'h0000_C300, 1'b0, g);
    e = '{lat: 3, err: 1'b0, reqc: 1, be: 4'b0010, maddr: 32'h0000_8000, we: 1'b0,
          wdata: 32'h0, rdata: 32'h0000_00C3};
    cmp("post_reset_load", g, e);
    exp_rdata = 32'h0000_00C3;

    for (int i = 0; i < 150; i++) begin
      r_st   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_a    = $urandom;
      if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
      r_wd   = $urandom;
      r_word = $urandom;
      r_gd   = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
      r_rd   = ($urandom_range(0, 9) == 0) ? 8 : int'($urandom_range(0, 3));
      e = model(r_st, r_f3, r_a, r_wd, r_gd, r_rd, r_word, exp_rdata);
      run_access(r_st, r_f3, r_a, r_wd, r_gd, r_rd, r_word, 1'b1, g);
      cmp($sformatf("rnd%0d", i), g, e);
      exp_rdata = e.rdata;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multicycle memory-access stage directly downstream of the register-file/function-unit datapath.
- Consumes the datapath's address output (rs1 register data) and store-data output (rs2 or constant).
- Performs RV32I byte/half/word loads and stores over a simple req/gnt/rvalid memory bus.
- Returns aligned, sign- or zero-extended load data for the datapath's DataIn write-back path.

Parameters:
- width, 32: data and address width; only 32 is supported.
- TIMEOUT, 255: maximum cycles spent in REQ+WAIT before aborting with error; must be at least 2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin an access; sampled only in IDLE.
- is_store  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  input  width  byte address (datapath AddrOut).
- wdata  input  width  store data (datapath DataOut).
- busy  output  1  high in REQ and WAIT.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; misaligned access, illegal funct3, or timeout.
- rdata  output  width  load result for datapath DataIn.
- mem_req  output  1  bus request.
- mem_we  output  1  bus write enable.
- mem_addr  output  width  word-aligned address; bits [1:0] are always 00.
- mem_be  output  4  byte enables.
- mem_wdata  output  width  lane-replicated store data.
- mem_gnt  input  1  request accepted.
- mem_rvalid  input  1  read data valid.
- mem_rdata  input  width  read data word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset (async, rst=0): state IDLE; busy, done, err, mem_req, mem_we, mem_be, rdata, mem_addr, mem_wdata and the timeout counter are all 0.
- Reset asserted mid-transaction abandons the access immediately; no done pulse is produced.
- IDLE, start=1, access legal:
  - Latch addr, wdata, funct3 and is_store; clear the timeout counter; go to REQ.
- IDLE, start=1, access illegal:
  - Illegal means funct3 is 011, 110 or 111; or a halfword with addr[0]=1; or a word with addr[1:0]!=00.
  - Go to DONE with err=1. No bus activity. rdata is unchanged.
  - Store-type funct3 100/101 are also illegal.
- start outside IDLE is ignored.
- REQ:
  - mem_req=1, with mem_we, mem_addr, mem_be and mem_wdata held stable until grant.
  - mem_gnt=1: a store goes to DONE; a load goes to WAIT. mem_req drops on the next cycle.
- WAIT:
  - mem_rvalid=1: extract the lane selected by the latched addr[1:0]. Byte = mem_rdata[8*off+7:8*off]; half = mem_rdata[16*off[1]+15:16*off[1]].
  - Sign-extend for B/H, zero-extend for BU/HU; word passes through.
  - Register the result into rdata and go to DONE.
  - mem_rvalid outside WAIT is ignored.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without the awaited gnt/rvalid, go to DONE with err=1. mem_req deasserts and rdata is unchanged.
  - Simultaneous gnt/rvalid and timeout: the handshake wins.
- DONE: done=1 and err valid for exactly one cycle, then IDLE. A start in DONE is ignored.
- Store encoding:
  - B: be = 0001 << off; wdata = {4{wdata[7:0]}}.
  - H: be = 0011 << off; wdata = {2{wdata[15:0]}}.
  - W: be = 1111; wdata = wdata.
  - mem_be = 0 whenever mem_req=0.
- Latency, zero-wait bus (gnt in the first REQ cycle, rvalid in the first WAIT cycle), with start at cycle T:
  - Load: done at T+3.
  - Store: done at T+2.
  - Error: done at T+1.
- rdata holds its last successful load result across stores and errors.

Decomposition:
- Package lsu_pkg holds:
  - the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum (IDLE/REQ/WAIT/DONE);
  - a helper function computing the byte-enable mask.
- One sub-module, load_align: combinational lane extraction plus sign/zero extension. Inputs: mem_rdata, off[1:0], funct3. Output: 32-bit result.

Test Plan:
- Load byte: addr=0x0000_1003, funct3=000, mem_rdata=0x80FF_1234, zero-wait bus -> mem_addr=0x1000, mem_be=1000, done at T+3, rdata=0xFFFF_FF80, err=0.
- Load half unsigned: addr=0x2002, funct3=101, mem_rdata=0xBEEF_0000 -> rdata=0x0000_BEEF. Same with funct3=001 -> rdata=0xFFFF_BEEF.
- Store half: addr=0x0010_0002, funct3=001, wdata=0x1234_ABCD, mem_gnt delayed 3 cycles -> mem_req held 4 cycles, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, done two cycles after start from the grant (one cycle after grant).
- Misaligned word load: addr=0x0000_0006, funct3=010 -> done and err=1 at T+1, mem_req never asserted, rdata unchanged.
- Timeout: load with mem_gnt tied to 0, TIMEOUT=8 -> mem_req high 8 cycles, then done=1 and err=1, rdata unchanged. A subsequent legal load completes normally.
- Reset mid-WAIT: rst=0 while in WAIT -> all outputs 0 asynchronously, no done pulse. A late mem_rvalid after reset release is ignored.
